// File: rtl/iter_divider.sv
// Multi-cycle unsigned divider (radix-2 restoring, one quotient bit per cycle).
// Executes the DIV (4'b1100) and REM (4'b1101) codes next to the ALU and
// reports its result with the ALU flag layout {negative, zero, carry, overflow}.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             sel_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;

    logic             accept;
    logic             run_step;

    // One restoring step: the shifted partial remainder is WIDTH+1 bits wide so
    // divisors above 2^(WIDTH-1) still compare correctly.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             quo_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] run_res;
    logic [WIDTH-1:0] dbz_res;

    // Datapath for a single iteration and for the divide-by-zero shortcut.
    always_comb begin
        rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dsr_reg};
        quo_bit   = ~rem_diff[WIDTH];
        rem_step  = quo_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_reg[WIDTH-2:0], quo_bit};
        run_res   = sel_reg ? rem_step : quo_step;
        dbz_res   = alu_control[0] ? op1 : {WIDTH{1'b1}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status outputs; flush squashes RUN/DONE and blocks accept.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        valid      = 1'b0;
        accept     = 1'b0;
        run_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && (alu_control[3:1] == 3'b110) && !flush) begin
                    accept     = 1'b1;
                    state_next = (op2 == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    run_step = 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                valid      = !flush;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latching, iteration registers and the result/flag registers
    // (the latter only change on the edge that enters DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dsr_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            sel_reg    <= 1'b0;
            result_reg <= '0;
            flags_reg  <= 4'b0100;
        end else if (accept) begin
            dvd_reg <= op1;
            dsr_reg <= op2;
            sel_reg <= alu_control[0];
            quo_reg <= '0;
            rem_reg <= '0;
            cnt_reg <= CW'(WIDTH);
            if (op2 == '0) begin
                result_reg <= dbz_res;
                flags_reg  <= {dbz_res[WIDTH-1], (dbz_res == '0), 1'b0, 1'b1};
            end
        end else if (run_step) begin
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                result_reg <= run_res;
                flags_reg  <= {run_res[WIDTH-1], (run_res == '0), 1'b0, 1'b0};
            end
        end
    end

    assign result = result_reg;
    assign flags  = flags_reg;

endmodule

// File: tb/tb_iter_divider.sv
// Directed testbench for iter_divider (WIDTH=32) with hand-computed expectations.
module tb_iter_divider;

    localparam int W = 32;
    localparam logic [3:0] C_DIV = 4'b1100;
    localparam logic [3:0] C_REM = 4'b1101;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alu_control = 4'b0000;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         valid;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int vectors = 0;
    int miscompares = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .op1         (op1),
        .op2         (op2),
        .flush       (flush),
        .busy        (busy),
        .valid       (valid),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] code);
        op1 = a;
        op2 = b;
        alu_control = code;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op1 = 32'hDEAD_BEEF;
        op2 = 32'h0000_0003;
    endtask

    // Wait (bounded) for valid, checking latency, result, flags and the one-cycle pulse.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        int cyc = 0;
        int busy_cnt = 0;
        while (!valid && cyc < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat);
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, {28'd0, flags}, {28'd0, exp_flags});
        $display("op %s: result=%h flags=%b after %0d cycles", tag, result, flags, cyc);
        @(negedge clk);
        check({tag, " valid_pulse"}, {31'd0, valid}, 32'd0);
    endtask

    // Count any busy/valid activity over n cycles; none is expected.
    task automatic idle_check(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            if (busy || valid) act++;
            @(negedge clk);
        end
        check({tag, " idle_activity"}, act, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {28'd0, flags}, 32'h4);
        rst = 1'b0;
        @(negedge clk);

        // Basic quotient / remainder and extreme operands
        launch(32'd100, 32'd7, C_DIV);
        wait_result("div 100/7", 32, 32'd14, 4'b0000);
        // Back-to-back: start in the IDLE cycle right after valid
        launch(32'd81, 32'd9, C_DIV);
        wait_result("b2b 81/9", 32, 32'd9, 4'b0000);
        launch(32'd100, 32'd7, C_REM);
        wait_result("rem 100%7", 32, 32'd2, 4'b0000);
        launch(32'hFFFF_FFFF, 32'd1, C_DIV);
        wait_result("div max/1", 32, 32'hFFFF_FFFF, 4'b1000);
        launch(32'd5, 32'd9, C_DIV);
        wait_result("div 5/9", 32, 32'd0, 4'b0100);
        launch(32'hFFFF_FFFF, 32'h8000_0001, C_DIV);
        wait_result("div big divisor", 32, 32'd1, 4'b0000);
        launch(32'hFFFF_FFFF, 32'h8000_0001, C_REM);
        wait_result("rem big divisor", 32, 32'h7FFF_FFFE, 4'b0000);

        // Divide by zero
        launch(32'h1234_5678, 32'd0, C_DIV);
        wait_result("dbz div", 0, 32'hFFFF_FFFF, 4'b1001);
        launch(32'h1234_5678, 32'd0, C_REM);
        wait_result("dbz rem", 0, 32'h1234_5678, 4'b0001);

        // Unsupported code is ignored
        op1 = 32'd100; op2 = 32'd7; alu_control = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_check("code 0000", 40);
        check("code 0000 result held", result, 32'h1234_5678);

        // Start while busy is ignored
        launch(32'd100, 32'd7, C_DIV);
        repeat (9) @(negedge clk);
        op1 = 32'd50; op2 = 32'd5; alu_control = C_DIV; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("busy ignore", 22, 32'd14, 4'b0000);
        idle_check("busy ignore second req", 40);

        // Flush mid-run: no pulse, previous result kept, then a clean new op
        launch(32'd1000, 32'd3, C_REM);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        idle_check("flush", 40);
        check("flush result held", result, 32'd14);
        check("flush flags held", {28'd0, flags}, 32'h0);
        launch(32'd100, 32'd7, C_DIV);
        wait_result("after flush", 32, 32'd14, 4'b0000);

        // Reset mid-run
        launch(32'd1000, 32'd3, C_DIV);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun rst busy", {31'd0, busy}, 32'd0);
        check("midrun rst result", result, 32'd0);
        check("midrun rst flags", {28'd0, flags}, 32'h4);
        idle_check("midrun rst", 40);
        launch(32'd81, 32'd9, C_DIV);
        wait_result("after rst", 32, 32'd9, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
